// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage access sequencer.
// Mask encodings match the decoder's byte-mask controls.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_ALIGN   = 2'b01,
    F_TIMEOUT = 2'b10,
    F_BUSERR  = 2'b11
  } fault_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Exactly one direction, a known size, and natural alignment for that size.
  function automatic logic access_legal(input logic [3:0] rd, input logic [3:0] wr,
                                        input logic [1:0] ofs);
    logic [3:0] m;
    logic       ok;
    ok = (rd != 4'd0) != (wr != 4'd0);
    m  = (rd != 4'd0) ? rd : wr;
    case (m)
      MASK_B:  ;
      MASK_H:  if (ofs[0]) ok = 1'b0;
      MASK_W:  if (ofs != 2'd0) ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [3:0] m, input logic [31:0] w);
    logic [31:0] r;
    case (m)
      MASK_B:  r = {4{w[7:0]}};
      MASK_H:  r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load lane extraction: shift the addressed byte lane down, keep the access
// width, then sign- or zero-fill. Word loads pass through unchanged.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  mask,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    result = shifted;
    case (mask)
      MASK_B:  result = {{24{sign & shifted[7]}}, shifted[7:0]};
      MASK_H:  result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one req/ack bus transaction per load/store, stalling
// the pipeline until the access completes, faults, or times out.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stage_valid,
  input  logic [3:0]  mem_read,
  input  logic [3:0]  mem_write,
  input  logic        mem_sign_extend,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        pipe_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  state_dbg
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  // Handshake: bus_req/bus_we/bus_addr/bus_be/bus_wdata are registered and held
  // from the cycle after acceptance until the cycle after ack, err or timeout;
  // bus_ack/bus_err/bus_rdata are only looked at while in REQ, err beats ack.

  state_t      state;
  fault_t      fault_q;
  logic [15:0] cnt;
  logic [1:0]  lat_ofs;
  logic [3:0]  lat_mask;
  logic        lat_sign;
  logic        lat_read;

  logic        access_present;
  logic        legal;
  logic [3:0]  acc_mask;
  logic [31:0] aligned;

  assign access_present = stage_valid && ((mem_read != 4'd0) || (mem_write != 4'd0));
  assign legal          = access_legal(mem_read, mem_write, addr[1:0]);
  assign acc_mask       = (mem_read != 4'd0) ? mem_read : mem_write;

  // Stall drops with reset so a discarded access never holds the pipeline.
  assign pipe_stall = rst_n && (((state == IDLE) && access_present) || (state == REQ));
  assign fault_code = fault_q;
  assign state_dbg  = state;

  mem_load_align u_align (
    .rdata  (bus_rdata),
    .addr   (lat_ofs),
    .mask   (lat_mask),
    .sign   (lat_sign),
    .result (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fault_q    <= F_NONE;
      cnt        <= 16'd0;
      lat_ofs    <= 2'd0;
      lat_mask   <= 4'd0;
      lat_sign   <= 1'b0;
      lat_read   <= 1'b0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
    end else begin
      load_valid <= 1'b0;
      fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (access_present) begin
            if (legal) begin
              lat_ofs   <= addr[1:0];
              lat_mask  <= acc_mask;
              lat_sign  <= mem_sign_extend;
              lat_read  <= (mem_read != 4'd0);
              bus_req   <= 1'b1;
              bus_we    <= (mem_write != 4'd0);
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= acc_mask << addr[1:0];
              bus_wdata <= store_lanes(acc_mask, wdata);
              cnt       <= 16'd0;
              state     <= REQ;
            end else begin
              fault   <= 1'b1;
              fault_q <= F_ALIGN;
              state   <= DONE;
            end
          end
        end
        REQ: begin
          if (bus_err) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            fault   <= 1'b1;
            fault_q <= F_BUSERR;
            state   <= DONE;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (lat_read) begin
              load_data  <= aligned;
              load_valid <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            fault   <= 1'b1;
            fault_q <= F_TIMEOUT;
            state   <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          fault_q <= F_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level model predicts every cycle of
// each access; a compare process checks the DUT against the expected queue.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        stage_valid;
  logic [3:0]  mem_read;
  logic [3:0]  mem_write;
  logic        mem_sign_extend;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        pipe_stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic [1:0]  fault_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic [1:0]  state_dbg;

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stage_valid     (stage_valid),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_sign_extend (mem_sign_extend),
    .addr            (addr),
    .wdata           (wdata),
    .pipe_stall      (pipe_stall),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .fault           (fault),
    .fault_code      (fault_code),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_wdata       (bus_wdata),
    .bus_ack         (bus_ack),
    .bus_err         (bus_err),
    .bus_rdata       (bus_rdata),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        lv;
    logic        flt;
    logic [1:0]  fc;
    logic [31:0] ld;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_ld = 32'd0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_cnt = 0;
  int          req_cnt   = 0;
  logic [1:0]  last_fc   = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input int ofs,
                                             input int size, input logic sx);
    logic [31:0] v;
    logic [31:0] keep;
    v = w >> (8 * ofs);
    if (size == 4) return v;
    keep = (32'd1 << (8 * size)) - 32'd1;
    v = v & keep;
    if (sx && v[8*size-1]) v = v | ~keep;
    return v;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus_req) req_cnt++;
      if (pipe_stall) stall_cnt++;
      if (fault) last_fc = fault_code;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pipe_stall", 32'(pipe_stall), 32'(e.stall));
        check("bus_req", 32'(bus_req), 32'(e.req));
        if (e.req) begin
          check("bus_we", 32'(bus_we), 32'(e.we));
          check("bus_addr", bus_addr, e.baddr);
          check("bus_be", 32'(bus_be), 32'(e.be));
          check("bus_wdata", bus_wdata, e.bwd);
        end
        check("load_valid", 32'(load_valid), 32'(e.lv));
        check("fault", 32'(fault), 32'(e.flt));
        check("fault_code", 32'(fault_code), 32'(e.fc));
        check("load_data", load_data, e.ld);
      end
    end
  end

  // ---------------- driver ----------------
  // resp: 0 ack, 1 err, 2 silent; dly = REQ cycle index of the response.
  task automatic do_access(input logic sv, input logic [3:0] rd, input logic [3:0] wr,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd,
                           input int resp, input int dly, input logic [31:0] rdat);
    exp_t e;
    bit   present;
    bit   legal;
    bit   responded;
    int   size;
    int   ofs;
    int   n_req;
    logic [3:0] m;

    present = sv && (rd != 4'd0 || wr != 4'd0);
    m       = (rd != 4'd0) ? rd : wr;
    size    = (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : (m == 4'b1111) ? 4 : 0;
    ofs     = int'(a[1:0]);
    legal   = ((rd != 4'd0) != (wr != 4'd0)) && (size != 0);
    if (legal && (ofs % size) != 0) legal = 0;

    stage_valid     = sv;
    mem_read        = rd;
    mem_write       = wr;
    mem_sign_extend = sx;
    addr            = a;
    wdata           = wd;
    bus_ack         = 1'($urandom_range(0, 1));
    bus_err         = 1'($urandom_range(0, 1));
    bus_rdata       = $urandom;

    e = '{default: '0};
    e.stall = present;
    e.ld    = model_ld;
    exp_q.push_back(e);
    @(negedge clk);
    if (!present) return;

    if (!legal) begin
      e.stall = 0;
      e.flt   = 1;
      e.fc    = 2'b01;
      bus_ack = 1'($urandom_range(0, 1));
      exp_q.push_back(e);
      @(negedge clk);
      return;
    end

    responded = (resp != 2) && (dly < TMO);
    n_req     = responded ? dly + 1 : TMO;
    e.stall   = 1;
    e.req     = 1;
    e.we      = (wr != 4'd0);
    e.baddr   = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++) e.be[i] = (i >= ofs) && (i < ofs + size);
    e.bwd = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
    for (int j = 0; j < n_req; j++) begin
      bus_ack   = (resp == 0 && j == dly);
      bus_err   = (resp == 1 && j == dly);
      if (resp == 1 && j == dly) bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = (j == dly) ? rdat : $urandom;
      exp_q.push_back(e);
      @(negedge clk);
    end

    e.stall   = 0;
    e.req     = 0;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_err   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    if (!responded) begin
      e.flt = 1;
      e.fc  = 2'b10;
    end else if (resp == 1) begin
      e.flt = 1;
      e.fc  = 2'b11;
    end else if (rd != 4'd0) begin
      model_ld = model_load(rdat, ofs, size, sx);
      e.lv     = 1;
      e.ld     = model_ld;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [3:0] pick_mask(input int k);
    case (k)
      0:       return 4'b0001;
      1:       return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    stage_valid = 1'b0;
    mem_read = 4'd0;
    mem_write = 4'd0;
    mem_sign_extend = 1'b0;
    addr = 32'd0;
    wdata = 32'd0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW 0x100, ack in first REQ cycle
    stall_cnt = 0;
    do_access(1, 4'hF, 4'h0, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    check("lw_lit_data", load_data, 32'hDEADBEEF);
    check("lw_lit_stalls", stall_cnt, 32'd2);

    // LBS / LB at 0x103
    do_access(1, 4'h1, 4'h0, 1, 32'h103, 32'h0, 0, 0, 32'h80123456);
    check("lbs_lit_data", load_data, 32'hFFFFFF80);
    do_access(1, 4'h1, 4'h0, 0, 32'h103, 32'h0, 0, 1, 32'h80123456);
    check("lb_lit_data", load_data, 32'h00000080);

    // SH 0x22: store leaves load_data alone
    do_access(1, 4'h0, 4'h3, 0, 32'h22, 32'h1234ABCD, 0, 1, 32'h0);
    check("sh_lit_keep", load_data, 32'h00000080);

    // Misaligned LW and dual-direction access
    stall_cnt = 0; req_cnt = 0; last_fc = 2'b00;
    do_access(1, 4'hF, 4'h0, 0, 32'h102, 32'h0, 0, 0, 32'h0);
    check("mis_lit_fc", 32'(last_fc), 32'd1);
    check("mis_lit_stalls", stall_cnt, 32'd1);
    check("mis_lit_req", req_cnt, 32'd0);
    last_fc = 2'b00;
    do_access(1, 4'h1, 4'h1, 0, 32'h100, 32'h0, 0, 0, 32'h0);
    check("dual_lit_fc", 32'(last_fc), 32'd1);

    // Timeout and bus error
    req_cnt = 0; last_fc = 2'b00;
    do_access(1, 4'hF, 4'h0, 0, 32'h200, 32'h0, 2, 0, 32'h0);
    check("tmo_lit_req", req_cnt, 32'd4);
    check("tmo_lit_fc", 32'(last_fc), 32'd2);
    req_cnt = 0; last_fc = 2'b00;
    do_access(1, 4'hF, 4'h0, 0, 32'h204, 32'h0, 1, 1, 32'h0);
    check("err_lit_req", req_cnt, 32'd2);
    check("err_lit_fc", 32'(last_fc), 32'd3);
    // Ack on the very last allowed cycle beats the timeout
    do_access(1, 4'h3, 4'h0, 1, 32'h206, 32'h0, 0, TMO - 1, 32'hF00D0000);

    // stage_valid low: masks ignored
    do_access(0, 4'hF, 4'h0, 0, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(0, 4'h1, 4'h3, 0, 32'h101, 32'h0, 0, 0, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [3:0]  rd;
      logic [3:0]  wr;
      logic [31:0] a;
      int          kind;
      int          r2;
      int          resp;
      kind = $urandom_range(0, 9);
      rd = 4'd0;
      wr = 4'd0;
      if (kind <= 3) rd = pick_mask($urandom_range(0, 2));
      else if (kind <= 6) wr = pick_mask($urandom_range(0, 2));
      else if (kind == 7) begin
        rd = pick_mask($urandom_range(0, 2));
        wr = pick_mask($urandom_range(0, 2));
      end else if (kind == 8) rd = 4'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rd == 4'b0011 || wr == 4'b0011) a[0] = 1'b0;
        if (rd == 4'b1111 || wr == 4'b1111) a[1:0] = 2'b00;
      end
      r2 = $urandom_range(0, 9);
      resp = (r2 < 7) ? 0 : (r2 < 9) ? 1 : 2;
      do_access(1'($urandom_range(0, 9) != 0), rd, wr, 1'($urandom_range(0, 1)), a,
                $urandom, resp, $urandom_range(0, 5), $urandom);
    end

    // Reset in the middle of REQ
    stage_valid = 1'b1;
    mem_read = 4'hF;
    mem_write = 4'h0;
    addr = 32'h300;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("mid_req_active", 32'(bus_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd0);
    check("mid_rst_stall", 32'(pipe_stall), 32'd0);
    check("mid_rst_fault", 32'(fault), 32'd0);
    stage_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ld = 32'd0;
    do_access(1, 4'hF, 4'h0, 0, 32'h300, 32'h0, 0, 0, 32'h13579BDF);
    check("post_rst_lit_data", load_data, 32'h13579BDF);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_q_drain: %0d entries left, 0 required", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
